// File: rtl/reaction_pkg.sv
// Shared definitions for the reaction-time game: controller state codes, counter widths
// and saturation limits. Imported by the controller and by reaction_timebase.
package reaction_pkg;

  localparam logic [2:0] CMD_CLEAR = 3'b000;
  localparam logic [2:0] CMD_START = 3'b001;
  localparam logic [2:0] CMD_STOP  = 3'b010;
  localparam logic [2:0] CMD_TIME  = 3'b100;
  localparam logic [2:0] CMD_ERROR = 3'b011;

  localparam int unsigned SEC_W = 7;
  localparam int unsigned MS_W  = 10;

  localparam logic [SEC_W-1:0] SEC_MAX = 7'd127;
  localparam logic [MS_W-1:0]  MS_MAX  = 10'd1023;

  // Codes the controller never produces behave like clear.
  function automatic logic [2:0] cmd_decode(input logic [2:0] code);
    case (code)
      CMD_START, CMD_STOP, CMD_TIME, CMD_ERROR: cmd_decode = code;
      default:                                  cmd_decode = CMD_CLEAR;
    endcase
  endfunction

endpackage

// File: rtl/reaction_timebase_if.sv
// Controller-facing bundle of the timing engine: state code and raw button in,
// conditioned button, elapsed-time counters and latched result out.
interface reaction_timebase_if;
  import reaction_pkg::*;

  logic [2:0]       cmd;
  logic             btn_raw;
  logic             btn_clean;
  logic [SEC_W-1:0] counter5;
  logic [MS_W-1:0]  counter1;
  logic             ms_tick;
  logic [MS_W-1:0]  result_ms;
  logic             result_valid;
  logic             timeout;

  modport master (
    output cmd, btn_raw,
    input  btn_clean, counter5, counter1, ms_tick, result_ms, result_valid, timeout
  );

  modport slave (
    input  cmd, btn_raw,
    output btn_clean, counter5, counter1, ms_tick, result_ms, result_valid, timeout
  );

endinterface

// File: rtl/reaction_timebase_ms_prescaler.sv
// Millisecond prescaler: divides clk by CLK_HZ/1000 and emits a registered one-cycle tick.
// clear restarts the count so the next tick lands exactly CLK_HZ/1000 cycles later.
module ms_prescaler #(
  parameter int unsigned CLK_HZ = 50_000_000
) (
  input  logic clk,
  input  logic rstn,
  input  logic clear,
  input  logic enable,
  output logic ms_tick
);

  localparam int unsigned DIV   = CLK_HZ / 1000;
  localparam int unsigned CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CNT_W-1:0] TC = CNT_W'(DIV - 1);
  // The clearing cycle itself counts as count 0.
  localparam logic [CNT_W-1:0] RESTART = (DIV > 1) ? CNT_W'(1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tick_q, tick_d;

  always_comb begin
    cnt_d  = cnt_q;
    tick_d = 1'b0;
    if (!enable) begin
      cnt_d = '0;
    end else if (clear) begin
      cnt_d = RESTART;
    end else if (cnt_q == TC) begin
      cnt_d  = '0;
      tick_d = 1'b1;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      tick_q <= tick_d;
    end
  end

  assign ms_tick = tick_q;

endmodule

// File: rtl/reaction_timebase.sv
// Timing engine for the reaction-time game: start-phase seconds, stop-phase milliseconds,
// result latch and button conditioning. Optional debouncer: REACTION_TIMEBASE_DEBOUNCE_EN.
module reaction_timebase
  import reaction_pkg::*;
#(
  parameter int unsigned CLK_HZ      = 50_000_000,
  parameter int unsigned MS_PER_S    = 1000,
  parameter int unsigned DEBOUNCE_MS = 10
) (
  input logic                clk,
  input logic                rstn,
  reaction_timebase_if.slave bus
);

  localparam int unsigned SUB_W = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
  localparam logic [SUB_W-1:0] SUB_MAX = SUB_W'(MS_PER_S - 1);

  logic [2:0]       cmd_eff, cmd_q;
  logic             entry, run, tick, use_tick;
  logic [SUB_W-1:0] sub_q, sub_d;
  logic [SEC_W-1:0] counter5_q, counter5_d;
  logic [MS_W-1:0]  counter1_q, counter1_d;
  logic [MS_W-1:0]  result_q, result_d;
  logic             valid_q, valid_d;
  logic             timeout_q, timeout_d;
  logic             sync1_q, sync2_q;

  assign cmd_eff  = cmd_decode(bus.cmd);
  assign entry    = (cmd_eff != cmd_q);
  assign run      = (cmd_eff == CMD_START) || (cmd_eff == CMD_STOP);
  // A tick left over from the previous phase never counts in the new one.
  assign use_tick = tick && !entry;

  ms_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (entry),
    .enable  (run),
    .ms_tick (tick)
  );

  always_comb begin
    sub_d      = sub_q;
    counter5_d = counter5_q;
    counter1_d = counter1_q;
    result_d   = result_q;
    valid_d    = valid_q;
    timeout_d  = timeout_q;
    case (cmd_eff)
      CMD_START: begin
        counter1_d = '0;
        if (use_tick) begin
          if (sub_q == SUB_MAX) begin
            sub_d = '0;
            if (counter5_q != SEC_MAX) counter5_d = counter5_q + 1'b1;
          end else begin
            sub_d = sub_q + 1'b1;
          end
        end
      end
      CMD_STOP: begin
        if (entry) begin
          counter1_d = '0;
        end else if (use_tick && (counter1_q != MS_MAX)) begin
          counter1_d = counter1_q + 1'b1;
        end
        if (counter1_d == MS_MAX) timeout_d = 1'b1;
      end
      CMD_TIME: begin
        if (entry) begin
          result_d = counter1_q;
          valid_d  = 1'b1;
        end
      end
      CMD_ERROR: begin
        valid_d = 1'b0;
      end
      default: begin
        sub_d      = '0;
        counter5_d = '0;
        counter1_d = '0;
        result_d   = '0;
        valid_d    = 1'b0;
        timeout_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cmd_q      <= CMD_CLEAR;
      sub_q      <= '0;
      counter5_q <= '0;
      counter1_q <= '0;
      result_q   <= '0;
      valid_q    <= 1'b0;
      timeout_q  <= 1'b0;
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
    end else begin
      cmd_q      <= cmd_eff;
      sub_q      <= sub_d;
      counter5_q <= counter5_d;
      counter1_q <= counter1_d;
      result_q   <= result_d;
      valid_q    <= valid_d;
      timeout_q  <= timeout_d;
      sync1_q    <= bus.btn_raw;
      sync2_q    <= sync1_q;
    end
  end

`ifdef REACTION_TIMEBASE_DEBOUNCE_EN
  localparam int unsigned DB_W = $clog2(DEBOUNCE_MS + 1);
  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_MS - 1);

  logic            db_tick;
  logic            db_q, db_d;
  logic [DB_W-1:0] db_cnt_q, db_cnt_d;

  // Free-running so the debounce window is independent of the game phase.
  ms_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_db_prescaler (
    .clk     (clk),
    .rstn    (rstn),
    .clear   (1'b0),
    .enable  (1'b1),
    .ms_tick (db_tick)
  );

  always_comb begin
    db_q_hold: begin
      db_d     = db_q;
      db_cnt_d = db_cnt_q;
    end
    if (sync2_q == db_q) begin
      db_cnt_d = '0;
    end else if (db_tick) begin
      if (db_cnt_q == DB_LAST) begin
        db_d     = sync2_q;
        db_cnt_d = '0;
      end else begin
        db_cnt_d = db_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      db_q     <= 1'b0;
      db_cnt_q <= '0;
    end else begin
      db_q     <= db_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  assign bus.btn_clean = db_q;
`else
  assign bus.btn_clean = sync2_q;
`endif

  assign bus.counter5     = counter5_q;
  assign bus.counter1     = counter1_q;
  assign bus.ms_tick      = tick;
  assign bus.result_ms    = result_q;
  assign bus.result_valid = valid_q;
  assign bus.timeout      = timeout_q;

endmodule

// File: tb/tb_reaction_timebase.sv
// Directed bench for reaction_timebase at CLK_HZ=10_000 (10 clk per ms).
// Button checks follow REACTION_TIMEBASE_DEBOUNCE_EN when it is defined.
module tb_reaction_timebase;
  import reaction_pkg::*;

  logic clk;
  logic rstn;
  int   n_checks;
  int   n_fail;

  reaction_timebase_if bus ();

  reaction_timebase #(
    .CLK_HZ      (10_000),
    .MS_PER_S    (1000),
    .DEBOUNCE_MS (10)
  ) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic check_zero(input string tag);
    check_eq({tag, ".btn_clean"},    32'(bus.btn_clean), 0);
    check_eq({tag, ".counter5"},     32'(bus.counter5), 0);
    check_eq({tag, ".counter1"},     32'(bus.counter1), 0);
    check_eq({tag, ".ms_tick"},      32'(bus.ms_tick), 0);
    check_eq({tag, ".result_ms"},    32'(bus.result_ms), 0);
    check_eq({tag, ".result_valid"}, 32'(bus.result_valid), 0);
    check_eq({tag, ".timeout"},      32'(bus.timeout), 0);
  endtask

  // Advance n rising edges, then settle 1 time unit past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    n_checks    = 0;
    n_fail      = 0;
    rstn        = 1'b0;
    bus.cmd     = CMD_CLEAR;
    bus.btn_raw = 1'b0;
    #22;
    check_zero("por");
    @(negedge clk);
    rstn = 1'b1;
    step(3);

    // Start: seconds tick at entry+10000+1 clk
    bus.cmd = CMD_START;
    step(10000);
    check_eq("start.c5_pre1", 32'(bus.counter5), 0);
    step(1);
    check_eq("start.c5_1", 32'(bus.counter5), 1);
    check_eq("start.c1_0", 32'(bus.counter1), 0);
    step(9999);
    check_eq("start.c5_pre2", 32'(bus.counter5), 1);
    step(1);
    check_eq("start.c5_2", 32'(bus.counter5), 2);
    step(10000);
    check_eq("start.c5_3", 32'(bus.counter5), 3);

    // Asynchronous reset mid-count
    step(5);
    rstn = 1'b0;
    #1;
    check_zero("rst_mid");
    bus.cmd = CMD_CLEAR;
    @(negedge clk);
    rstn = 1'b1;
    step(20);
    check_zero("rst_after");

    // Stop then time
    bus.cmd = CMD_STOP;
    step(9);
    check_eq("stop.tick_pre", 32'(bus.ms_tick), 0);
    step(1);
    check_eq("stop.tick", 32'(bus.ms_tick), 1);
    step(1);
    check_eq("stop.tick_off", 32'(bus.ms_tick), 0);
    check_eq("stop.c1_1", 32'(bus.counter1), 1);
    step(2490);
    check_eq("stop.c1_250", 32'(bus.counter1), 250);
    check_eq("stop.valid0", 32'(bus.result_valid), 0);
    bus.cmd = CMD_TIME;
    step(1);
    check_eq("time.result", 32'(bus.result_ms), 250);
    check_eq("time.valid", 32'(bus.result_valid), 1);
    step(100);
    check_eq("time.c1_hold", 32'(bus.counter1), 250);
    check_eq("time.result_hold", 32'(bus.result_ms), 250);
    check_eq("time.valid_hold", 32'(bus.result_valid), 1);
    check_eq("time.tick_off", 32'(bus.ms_tick), 0);

    // Clear, then saturation in stop
    bus.cmd = CMD_CLEAR;
    step(1);
    check_eq("clr.valid", 32'(bus.result_valid), 0);
    check_eq("clr.result", 32'(bus.result_ms), 0);
    check_eq("clr.c1", 32'(bus.counter1), 0);
    bus.cmd = CMD_STOP;
    step(10230);
    check_eq("sat.c1_1022", 32'(bus.counter1), 1022);
    check_eq("sat.to_pre", 32'(bus.timeout), 0);
    step(1);
    check_eq("sat.c1_1023", 32'(bus.counter1), 1023);
    check_eq("sat.to_set", 32'(bus.timeout), 1);
    step(769);
    check_eq("sat.c1_hold", 32'(bus.counter1), 1023);
    check_eq("sat.to_hold", 32'(bus.timeout), 1);
    bus.cmd = CMD_CLEAR;
    step(1);
    check_eq("sat.clr_c1", 32'(bus.counter1), 0);
    check_eq("sat.clr_to", 32'(bus.timeout), 0);

    // Error freezes; undefined code clears
    bus.cmd = CMD_START;
    step(20001);
    check_eq("err.c5_pre", 32'(bus.counter5), 2);
    bus.cmd = CMD_ERROR;
    step(50);
    check_eq("err.c5_frozen", 32'(bus.counter5), 2);
    check_eq("err.valid", 32'(bus.result_valid), 0);
    check_eq("err.tick", 32'(bus.ms_tick), 0);
    bus.cmd = 3'b111;
    step(1);
    check_eq("undef.c5", 32'(bus.counter5), 0);
    check_eq("undef.c1", 32'(bus.counter1), 0);
    bus.cmd = CMD_CLEAR;
    step(2);

    // Button path
`ifdef REACTION_TIMEBASE_DEBOUNCE_EN
    bus.btn_raw = 1'b1;
    step(30);
    bus.btn_raw = 1'b0;
    step(200);
    check_eq("db.glitch", 32'(bus.btn_clean), 0);
    bus.btn_raw = 1'b1;
    step(80);
    check_eq("db.press_early", 32'(bus.btn_clean), 0);
    step(45);
    check_eq("db.press_rise", 32'(bus.btn_clean), 1);
    step(25);
    bus.btn_raw = 1'b0;
    step(150);
    check_eq("db.release", 32'(bus.btn_clean), 0);
`else
    bus.btn_raw = 1'b1;
    step(1);
    check_eq("btn.lat1", 32'(bus.btn_clean), 0);
    step(1);
    check_eq("btn.lat2", 32'(bus.btn_clean), 1);
    bus.btn_raw = 1'b0;
    step(1);
    check_eq("btn.fall1", 32'(bus.btn_clean), 1);
    step(1);
    check_eq("btn.fall2", 32'(bus.btn_clean), 0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
